// File: rtl/exec_pkg.sv
// Shared encodings for the execute-side branch/stack-pointer stage:
// branch condition codes, flag bit positions and control FSM states.
package exec_pkg;

    localparam logic [2:0] COND_EQ = 3'b000;
    localparam logic [2:0] COND_LT = 3'b001;
    localparam logic [2:0] COND_LE = 3'b010;
    localparam logic [2:0] COND_NE = 3'b011;
    localparam logic [2:0] COND_AL = 3'b100;

    // Flag register layout is {S,Z,C,V}
    localparam int FLG_S = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } state_t;

endpackage

// File: rtl/exec_branch_sp_stage_cond_eval.sv
// Combinational branch-condition evaluator: condition code plus S/Z/V flags
// to a single taken/not-taken decision. Zero latency, no flow control.
module cond_eval
    import exec_pkg::*;
(
    input  logic [2:0] i_cond,
    input  logic       i_s,
    input  logic       i_z,
    input  logic       i_v,
    output logic       o_cond_true
);

    logic w_lt;
    assign w_lt = i_s ^ i_v;

    always_comb begin
        o_cond_true = 1'b0;
        case (i_cond)
            COND_EQ: o_cond_true = i_z;
            COND_LT: o_cond_true = w_lt;
            COND_LE: o_cond_true = i_z | w_lt;
            COND_NE: o_cond_true = ~i_z;
            COND_AL: o_cond_true = 1'b1;
            default: o_cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/exec_branch_sp_stage.sv
// Execute control stage: stack pointer, flag register, branch decision and
// wrong-path squash; 1-cycle latency, stall_IN freezes every register.
module exec_branch_sp_stage
    import exec_pkg::*;
#(
    parameter int                SP_W      = 8,
    parameter logic [SP_W-1:0]   SP_RESET  = 8'hFF,
    parameter int                FLUSH_CYC = 2
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            valid_IN,
    input  logic            stall_IN,
    input  logic [2:0]      cond_IN,
    input  logic            PC_load_IN,
    input  logic            SPR_w_IN,
    input  logic            SPR_i_IN,
    input  logic            SPR_d_IN,
    input  logic [SP_W-1:0] sp_data_IN,
    input  logic [3:0]      flags_IN,
    input  logic            flags_we_IN,
    input  logic            wren_IN,
    input  logic [2:0]      writeAd_IN,
    input  logic            write_IN,
    output logic [SP_W-1:0] sp_OUT,
    output logic [3:0]      flags_OUT,
    output logic            branch_taken_OUT,
    output logic            flush_OUT,
    output logic            sp_err_OUT,
    output logic            valid_OUT,
    output logic            wren_OUT,
    output logic [2:0]      writeAd_OUT,
    output logic            write_OUT
);

    localparam int CNT_W = 3;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [SP_W-1:0]   r_sp;
    logic              r_sp_err;
    logic [3:0]        r_flags;
    logic              r_taken;
    logic              r_valid;
    logic              r_wren;
    logic [2:0]        r_writeAd;
    logic              r_write;
    logic              w_eff;
    logic              w_cond_true;
    logic              w_taken;

    assign w_eff   = valid_IN & ~stall_IN & (r_state == ST_RUN);
    assign w_taken = w_eff & PC_load_IN & w_cond_true;

    // Decision uses the flag register as it stands, before this instruction's write
    cond_eval u_cond_eval (
        .i_cond      (cond_IN),
        .i_s         (r_flags[FLG_S]),
        .i_z         (r_flags[FLG_Z]),
        .i_v         (r_flags[FLG_V]),
        .o_cond_true (w_cond_true)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_RUN: begin
                if (w_taken) begin
                    w_state_nxt = ST_SQUASH;
                    w_cnt_nxt   = CNT_W'(FLUSH_CYC);
                end
            end
            ST_SQUASH: begin
                // Countdown runs on every non-stalled cycle, valid or not
                if (!stall_IN) begin
                    if (r_cnt <= CNT_W'(1)) begin
                        w_state_nxt = ST_RUN;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt - CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= ST_RUN;
            r_cnt     <= '0;
            r_sp      <= SP_RESET;
            r_sp_err  <= 1'b0;
            r_flags   <= '0;
            r_taken   <= 1'b0;
            r_valid   <= 1'b0;
            r_wren    <= 1'b0;
            r_writeAd <= '0;
            r_write   <= 1'b0;
        end else if (!stall_IN) begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_taken   <= w_taken;
            r_valid   <= w_eff;
            r_wren    <= wren_IN & w_eff;
            r_write   <= write_IN & w_eff;
            r_writeAd <= writeAd_IN;
            if (w_eff && flags_we_IN) begin
                r_flags <= flags_IN;
            end
            if (w_eff) begin
                if (SPR_w_IN) begin
                    r_sp <= sp_data_IN;
                end else if (SPR_i_IN) begin
                    r_sp <= r_sp + 1'b1;
                    if (r_sp == '1) r_sp_err <= 1'b1;
                end else if (SPR_d_IN) begin
                    r_sp <= r_sp - 1'b1;
                    if (r_sp == '0) r_sp_err <= 1'b1;
                end
            end
        end
    end

    assign sp_OUT           = r_sp;
    assign flags_OUT        = r_flags;
    assign branch_taken_OUT = r_taken;
    assign flush_OUT        = (r_state == ST_SQUASH);
    assign sp_err_OUT       = r_sp_err;
    assign valid_OUT        = r_valid;
    assign wren_OUT         = r_wren;
    assign writeAd_OUT      = r_writeAd;
    assign write_OUT        = r_write;

endmodule

// File: tb/tb_exec_branch_sp_stage.sv
// Directed bench for exec_branch_sp_stage: SP ops, wrap error, branch/squash,
// flag timing, stall freezing and asynchronous reset during squash.
module tb_exec_branch_sp_stage;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       valid_IN, stall_IN, PC_load_IN;
    logic [2:0] cond_IN;
    logic       SPR_w_IN, SPR_i_IN, SPR_d_IN;
    logic [7:0] sp_data_IN;
    logic [3:0] flags_IN;
    logic       flags_we_IN, wren_IN, write_IN;
    logic [2:0] writeAd_IN;
    logic [7:0] sp_OUT;
    logic [3:0] flags_OUT;
    logic       branch_taken_OUT, flush_OUT, sp_err_OUT;
    logic       valid_OUT, wren_OUT, write_OUT;
    logic [2:0] writeAd_OUT;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    exec_branch_sp_stage dut (
        .CLK              (CLK),
        .RST_N            (RST_N),
        .valid_IN         (valid_IN),
        .stall_IN         (stall_IN),
        .cond_IN          (cond_IN),
        .PC_load_IN       (PC_load_IN),
        .SPR_w_IN         (SPR_w_IN),
        .SPR_i_IN         (SPR_i_IN),
        .SPR_d_IN         (SPR_d_IN),
        .sp_data_IN       (sp_data_IN),
        .flags_IN         (flags_IN),
        .flags_we_IN      (flags_we_IN),
        .wren_IN          (wren_IN),
        .writeAd_IN       (writeAd_IN),
        .write_IN         (write_IN),
        .sp_OUT           (sp_OUT),
        .flags_OUT        (flags_OUT),
        .branch_taken_OUT (branch_taken_OUT),
        .flush_OUT        (flush_OUT),
        .sp_err_OUT       (sp_err_OUT),
        .valid_OUT        (valid_OUT),
        .wren_OUT         (wren_OUT),
        .writeAd_OUT      (writeAd_OUT),
        .write_OUT        (write_OUT)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        valid_IN = 0; stall_IN = 0; cond_IN = 3'b111; PC_load_IN = 0;
        SPR_w_IN = 0; SPR_i_IN = 0; SPR_d_IN = 0; sp_data_IN = 8'h00;
        flags_IN = 4'h0; flags_we_IN = 0; wren_IN = 0; writeAd_IN = 3'd0; write_IN = 0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST_N = 1'b0;
        idle();
        #12;
        chk("rst_sp", sp_OUT, 8'hFF);
        chk("rst_flags", {4'h0, flags_OUT}, 8'h00);
        chk("rst_ctl", {branch_taken_OUT, flush_OUT, sp_err_OUT, valid_OUT,
                        wren_OUT, write_OUT, writeAd_OUT[1:0]}, 8'h00);
        @(negedge CLK);
        RST_N = 1'b1;
        tick();
        chk("idle_sp", sp_OUT, 8'hFF);
        chk("idle_valid", {7'd0, valid_OUT}, 8'h00);

        // Load, inc, inc, dec with write-back fields riding along
        valid_IN = 1; SPR_w_IN = 1; sp_data_IN = 8'h10; wren_IN = 1; write_IN = 1; writeAd_IN = 3'd5;
        tick();
        chk("load_sp", sp_OUT, 8'h10);
        chk("load_wb", {valid_OUT, wren_OUT, write_OUT, writeAd_OUT}, {3'b111, 3'd5});
        SPR_w_IN = 0; SPR_i_IN = 1; wren_IN = 0; write_IN = 0;
        tick();
        chk("inc1_sp", sp_OUT, 8'h11);
        tick();
        chk("inc2_sp", sp_OUT, 8'h12);
        SPR_i_IN = 0; SPR_d_IN = 1;
        tick();
        chk("dec_sp", sp_OUT, 8'h11);

        // Invalid slot: controls gated, address still passes
        idle(); wren_IN = 1; write_IN = 1; writeAd_IN = 3'd3; SPR_i_IN = 1;
        tick();
        chk("inv_wb", {valid_OUT, wren_OUT, write_OUT, writeAd_OUT}, {3'b000, 3'd3});
        chk("inv_sp", sp_OUT, 8'h11);

        idle(); valid_IN = 1; SPR_w_IN = 1; SPR_i_IN = 1; SPR_d_IN = 1; sp_data_IN = 8'h40;
        tick();
        chk("prio_sp", sp_OUT, 8'h40);

        // Wrap on increment sets the sticky error; a later load leaves it set
        idle(); valid_IN = 1; SPR_w_IN = 1; sp_data_IN = 8'hFF;
        tick();
        chk("pre_wrap_err", {7'd0, sp_err_OUT}, 8'h00);
        idle(); valid_IN = 1; SPR_i_IN = 1;
        tick();
        chk("wrap_sp", sp_OUT, 8'h00);
        chk("wrap_err", {7'd0, sp_err_OUT}, 8'h01);
        idle(); valid_IN = 1; SPR_w_IN = 1; sp_data_IN = 8'h20;
        tick();
        chk("err_sticky", {sp_err_OUT, sp_OUT[6:0]}, 8'hA0);

        // BE with Z written by the same instruction: old Z=0 decides
        idle(); valid_IN = 1; PC_load_IN = 1; cond_IN = 3'b000; flags_we_IN = 1; flags_IN = 4'b0100;
        tick();
        chk("ftime_taken", {7'd0, branch_taken_OUT}, 8'h00);
        chk("ftime_flush", {7'd0, flush_OUT}, 8'h00);
        chk("ftime_flags", {4'h0, flags_OUT}, 8'h04);

        // NE and a never-code with Z=1: neither taken
        idle(); valid_IN = 1; PC_load_IN = 1; cond_IN = 3'b011;
        tick();
        chk("ne_taken", {7'd0, branch_taken_OUT}, 8'h00);
        cond_IN = 3'b101;
        tick();
        chk("never_taken", {flush_OUT, branch_taken_OUT}, 8'h00);

        // Taken BE carrying a push (call): both take effect
        idle(); valid_IN = 1; PC_load_IN = 1; cond_IN = 3'b000; SPR_i_IN = 1;
        tick();
        chk("be_taken", {7'd0, branch_taken_OUT}, 8'h01);
        chk("be_flush", {7'd0, flush_OUT}, 8'h01);
        chk("be_sp", sp_OUT, 8'h21);
        idle(); valid_IN = 1; wren_IN = 1; SPR_i_IN = 1;
        tick();
        chk("sq1_pulse", {flush_OUT, branch_taken_OUT}, 8'h02);
        chk("sq1_wb", {sp_OUT[5:0], valid_OUT, wren_OUT}, {6'h21, 2'b00});
        tick();
        chk("sq2_flush", {7'd0, flush_OUT}, 8'h00);
        chk("sq2_wb", {sp_OUT[5:0], valid_OUT, wren_OUT}, {6'h21, 2'b00});
        tick();
        chk("post_sq_sp", sp_OUT, 8'h22);
        chk("post_sq_wb", {valid_OUT, wren_OUT}, 8'h03);

        // Always-branch, then a 3-cycle stall inside the squash window
        idle(); valid_IN = 1; PC_load_IN = 1; cond_IN = 3'b100;
        tick();
        chk("al_taken", {flush_OUT, branch_taken_OUT, valid_OUT}, 8'h07);
        idle(); stall_IN = 1; valid_IN = 1; SPR_i_IN = 1; wren_IN = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold", {flush_OUT, branch_taken_OUT, valid_OUT, wren_OUT}, 8'h0E);
            chk("stall_sp", sp_OUT, 8'h22);
        end
        stall_IN = 0;
        tick();
        chk("st_sq1", {flush_OUT, branch_taken_OUT, valid_OUT}, 8'h04);
        tick();
        chk("st_sq2", {flush_OUT, valid_OUT}, 8'h00);
        chk("st_sq2_sp", sp_OUT, 8'h22);
        tick();
        chk("st_exec_sp", sp_OUT, 8'h23);

        // LT: set S=1,V=0, then branch on S^V
        idle(); valid_IN = 1; flags_we_IN = 1; flags_IN = 4'b1000;
        tick();
        idle(); valid_IN = 1; PC_load_IN = 1; cond_IN = 3'b001;
        tick();
        chk("lt_taken", {flush_OUT, branch_taken_OUT}, 8'h03);
        idle();
        tick();
        tick();
        chk("lt_done", {4'h0, flags_OUT}, 8'h08);
        chk("lt_flush_end", {7'd0, flush_OUT}, 8'h00);

        // Asynchronous reset mid-squash: flush drops without a clock edge
        idle(); valid_IN = 1; PC_load_IN = 1; cond_IN = 3'b100;
        tick();
        chk("pre_rst_flush", {7'd0, flush_OUT}, 8'h01);
        idle();
        #2 RST_N = 1'b0;
        #1;
        chk("arst_flush", {7'd0, flush_OUT}, 8'h00);
        chk("arst_sp", {sp_err_OUT, sp_OUT[6:0]}, 8'h7F);
        @(negedge CLK);
        RST_N = 1'b1;
        tick();
        chk("arst_after", {flush_OUT, branch_taken_OUT, valid_OUT}, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
